// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: central stall/flush generator for the five-stage pipeline.
// Latency: en_*/clr_* are combinational from inputs and divider state; div_busy/div_done are registered.
// Backpressure: mem_stall freezes every stage; divide and load-use hazards freeze the front end.
//
// Ports:
//   clk, rst (async active-low)        clock and reset
//   mem_stall                          memory not ready, freeze whole pipeline
//   ex_memread, ex_rt, id_rs, id_rt    load-use hazard detection inputs
//   ex_branch_taken                    taken branch/jump in EX, squash IF/ID work
//   ex_div                             DIV/DIVU sitting in EX
//   en_f/en_d/en_e/en_m/en_w           pipeline register enables
//   clr_d/clr_e/clr_m                  bubble inserts (always issued with the matching enable)
//   div_busy, div_done                 divider state decode
//   stall_cnt                          cycles with en_f low; only built when STALL_CNT_EN is defined
module hazard_stall_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_stall,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_div,
  output logic             en_f,
  output logic             en_d,
  output logic             en_e,
  output logic             en_m,
  output logic             en_w,
  output logic             clr_d,
  output logic             clr_e,
  output logic             clr_m,
  output logic             div_busy,
  output logic             div_done,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] CNT_INIT = 8'(DIV_CYCLES - 1);

  state_e     state_q;
  logic [7:0] cnt_q;
  logic       div_busy_q;
  logic       div_done_q;

  // Divider sequencing. BUSY runs DIV_CYCLES cycles regardless of mem_stall;
  // only the IDLE->BUSY launch and the DONE->IDLE retire wait for memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      div_busy_q <= 1'b0;
      div_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ex_div && !mem_stall) begin
            state_q    <= BUSY;
            cnt_q      <= CNT_INIT;
            div_busy_q <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt_q == 8'd0) begin
            state_q    <= DONE;
            div_busy_q <= 1'b0;
            div_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        DONE: begin
          if (!mem_stall) begin
            state_q    <= IDLE;
            div_done_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          cnt_q      <= 8'd0;
          div_busy_q <= 1'b0;
          div_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign div_busy = div_busy_q;
  assign div_done = div_done_q;

  logic load_use;
  logic div_stall;

  // r0 is hardwired zero, so a load "into" it never produces a real dependency.
  assign load_use  = ex_memread && (ex_rt != 5'd0) &&
                     ((ex_rt == id_rs) || (ex_rt == id_rt));
  // In DONE the divide has finished, so ex_div (still the same DIV) is ignored.
  assign div_stall = ((state_q == IDLE) && ex_div) || (state_q == BUSY);

  always_comb begin
    en_f  = 1'b1;
    en_d  = 1'b1;
    en_e  = 1'b1;
    en_m  = 1'b1;
    en_w  = 1'b1;
    clr_d = 1'b0;
    clr_e = 1'b0;
    clr_m = 1'b0;
    if (mem_stall) begin
      en_f = 1'b0;
      en_d = 1'b0;
      en_e = 1'b0;
      en_m = 1'b0;
      en_w = 1'b0;
    end else if (div_stall) begin
      // Hold the DIV in EX; drain MEM/WB and feed a bubble into MEM.
      en_f  = 1'b0;
      en_d  = 1'b0;
      en_e  = 1'b0;
      clr_m = 1'b1;
    end else if (ex_branch_taken) begin
      // Squash wrong-path work; any load-use match belongs to a dead instruction.
      clr_d = 1'b1;
      clr_e = 1'b1;
    end else if (load_use) begin
      en_f  = 1'b0;
      en_d  = 1'b0;
      clr_e = 1'b1;
    end
  end

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!en_f) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed and randomized checks of hazard_stall_ctrl against a cycle model.
// Latency: inputs driven on the falling edge, outputs sampled 2 time units later.
// Backpressure: mem_stall is exercised both in directed scenarios and randomly.
module tb_hazard_stall_ctrl;

  localparam int DIV = 4;
  localparam int CW  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_stall, ex_memread, ex_branch_taken, ex_div;
  logic [4:0]    ex_rt, id_rs, id_rt;
  logic          en_f, en_d, en_e, en_m, en_w, clr_d, clr_e, clr_m;
  logic          div_busy, div_done;
  logic [CW-1:0] stall_cnt;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.DIV_CYCLES(DIV), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .mem_stall(mem_stall), .ex_memread(ex_memread),
    .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt), .ex_branch_taken(ex_branch_taken),
    .ex_div(ex_div), .en_f(en_f), .en_d(en_d), .en_e(en_e), .en_m(en_m), .en_w(en_w),
    .clr_d(clr_d), .clr_e(clr_e), .clr_m(clr_m), .div_busy(div_busy), .div_done(div_done),
    .stall_cnt(stall_cnt)
  );

  // {en_f,en_d,en_e,en_m,en_w,clr_d,clr_e,clr_m,div_busy,div_done}
  wire [9:0] obs = {en_f, en_d, en_e, en_m, en_w, clr_d, clr_e, clr_m, div_busy, div_done};

  // Reference model: divider tracked as "BUSY cycles still to run" plus a
  // "result waiting to retire" flag; stall count as a plain integer.
  int            busy_left;
  bit            done_m;
  logic [CW-1:0] sc_m;

  function automatic logic [9:0] model_outs();
    bit divst, lu;
    logic [4:0] en;
    logic [2:0] clr;
    divst = (busy_left == 0 && !done_m && ex_div) || (busy_left > 0);
    lu    = ex_memread && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
    if (mem_stall)            begin en = 5'b00000; clr = 3'b000; end
    else if (divst)           begin en = 5'b00011; clr = 3'b001; end
    else if (ex_branch_taken) begin en = 5'b11111; clr = 3'b110; end
    else if (lu)              begin en = 5'b00111; clr = 3'b010; end
    else                      begin en = 5'b11111; clr = 3'b000; end
    return {en, clr, (busy_left > 0), done_m};
  endfunction

  function automatic logic [CW-1:0] exp_cnt();
`ifdef STALL_CNT_EN
    return sc_m;
`else
    return '0;
`endif
  endfunction

  task automatic model_step();
    logic [9:0] e;
    e = model_outs();
    if (!e[9]) sc_m = sc_m + 1;
    if (done_m) begin
      if (!mem_stall) done_m = 0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) done_m = 1;
    end else if (ex_div && !mem_stall) begin
      busy_left = DIV;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    mem_stall = 0; ex_memread = 0; ex_branch_taken = 0; ex_div = 0;
    ex_rt = 0; id_rs = 0; id_rt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 0;
    busy_left = 0; done_m = 0; sc_m = '0;
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    busy_left = 0; done_m = 0; sc_m = '0;
    @(negedge clk);
    #2;
    if (obs !== 10'b1111100000) begin errs++; $display("FAIL reset_held outs: got %b want %b", obs, 10'b1111100000); end
    vecs++;
    if (stall_cnt !== '0) begin errs++; $display("FAIL reset_held stall_cnt: got %0d want 0", stall_cnt); end
    vecs++;
    @(negedge clk);
    rst = 1;
    #2;
    if (obs !== 10'b1111100000) begin errs++; $display("FAIL reset_release outs: got %b want %b", obs, 10'b1111100000); end
    vecs++;
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_memread = 1; ex_rt = 5; id_rs = 5; id_rt = 9;
    #2;
    if (obs !== 10'b0011101000) begin errs++; $display("FAIL load_use_rs: got %b want %b", obs, 10'b0011101000); end
    vecs++;
    tick();
    id_rs = 7; id_rt = 5;
    #2;
    if (obs !== 10'b0011101000) begin errs++; $display("FAIL load_use_rt: got %b want %b", obs, 10'b0011101000); end
    vecs++;
    tick();
    ex_rt = 0; id_rs = 0; id_rt = 0;
    #2;
    if (obs !== 10'b1111100000) begin errs++; $display("FAIL load_use_r0: got %b want %b", obs, 10'b1111100000); end
    vecs++;
    tick();
    ex_memread = 0; ex_rt = 5; id_rs = 5;
    #2;
    if (obs !== 10'b1111100000) begin errs++; $display("FAIL load_use_noload: got %b want %b", obs, 10'b1111100000); end
    vecs++;
    tick();
    idle_inputs();
  endtask

  task automatic test_branch();
    do_reset();
    ex_branch_taken = 1; ex_memread = 1; ex_rt = 3; id_rs = 3;
    #2;
    if (obs !== 10'b1111111000) begin errs++; $display("FAIL branch_over_loaduse: got %b want %b", obs, 10'b1111111000); end
    vecs++;
    tick();
    idle_inputs();
  endtask

  task automatic test_divide();
    logic [9:0] want [7];
    want[0] = 10'b0001100100;
    for (int i = 1; i <= 4; i++) want[i] = 10'b0001100110;
    want[5] = 10'b1111100001;
    want[6] = 10'b1111100000;
    do_reset();
    ex_div = 1;
    for (int c = 0; c < 7; c++) begin
      if (c == 6) ex_div = 0;
      #2;
      if (obs !== want[c]) begin errs++; $display("FAIL divide cyc%0d: got %b want %b", c + 1, obs, want[c]); end
      vecs++;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_mem_stall_done();
    logic [9:0] want [9];
    want[0] = 10'b0001100100;
    for (int i = 1; i <= 4; i++) want[i] = 10'b0001100110;
    want[5] = 10'b0000000001;
    want[6] = 10'b0000000001;
    want[7] = 10'b1111100001;
    want[8] = 10'b1111100000;
    do_reset();
    ex_div = 1;
    for (int c = 0; c < 9; c++) begin
      mem_stall = (c == 5 || c == 6);
      if (c == 8) ex_div = 0;
      #2;
      if (obs !== want[c]) begin errs++; $display("FAIL memstall_done cyc%0d: got %b want %b", c + 1, obs, want[c]); end
      vecs++;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_div();
    do_reset();
    ex_div = 1;
    tick();
    tick();
    #2;
    if (div_busy !== 1'b1) begin errs++; $display("FAIL busy_before_reset: got %b want 1", div_busy); end
    vecs++;
    rst = 0;
    busy_left = 0; done_m = 0; sc_m = '0;
    #1;
    if ({div_busy, div_done} !== 2'b00) begin errs++; $display("FAIL async_reset busy/done: got %b want 00", {div_busy, div_done}); end
    vecs++;
    @(negedge clk);
    idle_inputs();
    rst = 1;
    #2;
    if (obs !== 10'b1111100000) begin errs++; $display("FAIL after_reset outs: got %b want %b", obs, 10'b1111100000); end
    vecs++;
    if (stall_cnt !== '0) begin errs++; $display("FAIL after_reset stall_cnt: got %0d want 0", stall_cnt); end
    vecs++;
    for (int c = 0; c < 6; c++) begin
      tick();
      #2;
      if (div_done !== 1'b0) begin errs++; $display("FAIL no_done_after_abort cyc%0d: got %b want 0", c, div_done); end
      vecs++;
    end
  endtask

  task automatic test_counter();
    logic [CW-1:0] want;
`ifdef STALL_CNT_EN
    want = 8;
`else
    want = 0;
`endif
    do_reset();
    for (int k = 0; k < 3; k++) begin
      ex_memread = 1; ex_rt = 5'(k + 1); id_rs = 5'(k + 1);
      tick();
      idle_inputs();
      tick();
    end
    ex_div = 1;
    repeat (DIV + 2) tick();
    ex_div = 0;
    tick();
    #2;
    if (stall_cnt !== want) begin errs++; $display("FAIL stall_cnt_total: got %0d want %0d", stall_cnt, want); end
    vecs++;
  endtask

  task automatic test_random();
    logic [9:0] e;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      mem_stall       = ($urandom_range(0, 7) == 0);
      ex_div          = ($urandom_range(0, 11) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      ex_memread      = $urandom_range(0, 1);
      ex_rt           = 5'($urandom_range(0, 3));
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      #2;
      e = model_outs();
      if (obs !== e) begin errs++; $display("FAIL random cyc%0d outs: got %b want %b", c, obs, e); end
      vecs++;
      if (stall_cnt !== exp_cnt()) begin errs++; $display("FAIL random cyc%0d stall_cnt: got %0d want %0d", c, stall_cnt, exp_cnt()); end
      vecs++;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_divide();
    test_mem_stall_done();
    test_reset_mid_div();
    test_counter();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

- Central stall/flush generator for the five-stage pipeline.
- Drives the per-stage `en`/`clear` pairs of the IF/ID/EX/MEM/WB pipeline registers.
- Handles four events: load-use hazards, taken-branch flushes, a multi-cycle divide resolved by an internal FSM/counter, and external memory stalls.
- Each pipeline register applies `clear` only when its `en` is also high. This block therefore always asserts `en` together with any `clear` it issues.

## Interface
Parameters:
- `DIV_CYCLES`, default 32: cycles the divider needs in BUSY. Legal range is 1..255.
- `CNT_W`, default 32: width of the stall performance counter.

Ports:
- `clk` input 1: clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-low reset; state clears immediately when `rst`=0.
- `mem_stall` input 1: data/instruction memory not ready; freeze whole pipeline.
- `ex_memread` input 1: instruction in EX is a load.
- `ex_rt` input 5: load destination register in EX.
- `id_rs`, `id_rt` input 5 each: source registers of the instruction in ID.
- `ex_branch_taken` input 1: branch/jump resolved taken in EX.
- `ex_div` input 1: instruction in EX is DIV/DIVU.
- `en_f`, `en_d`, `en_e`, `en_m`, `en_w` output 1 each: stage register enables.
- `clr_d`, `clr_e`, `clr_m` output 1 each: stage register bubble inserts.
- `div_busy` output 1: divider running (state BUSY).
- `div_done` output 1: divide result valid this cycle (state DONE).
- `stall_cnt` output `CNT_W`: count of cycles with `en_f`=0.

## Operation
- FSM states are IDLE, BUSY and DONE, with a down-counter of 8 bits.
- IDLE → BUSY: when `ex_div`=1 and `mem_stall`=0. The counter loads `DIV_CYCLES`-1.
- BUSY: the counter decrements each cycle. When the counter reaches 0, the FSM moves to DONE. BUSY therefore lasts exactly `DIV_CYCLES` cycles.
- DONE → IDLE: when `mem_stall`=0. If `mem_stall`=1, the FSM holds in DONE.
- Output priority, highest first; the first matching rule sets all outputs:
  1. `mem_stall`=1: all `en_*`=0 and all `clr_*`=0.
  2. Divide stall (IDLE with `ex_div`=1, or state BUSY):
     - `en_f`=`en_d`=`en_e`=0.
     - `en_m`=1 and `clr_m`=1, inserting a bubble into MEM.
     - `en_w`=1.
  3. `ex_branch_taken`=1: all `en_*`=1, `clr_d`=1, `clr_e`=1. Wrong-path IF/ID contents are squashed and load-use is ignored.
  4. Load-use: condition is `ex_memread`=1, `ex_rt`≠0, and (`ex_rt`==`id_rs` or `ex_rt`==`id_rt`).
     - `en_f`=`en_d`=0.
     - `en_e`=1 and `clr_e`=1.
     - `en_m`=`en_w`=1.
  5. Otherwise: all `en_*`=1 and all `clr_*`=0.
- DONE cycle:
  - `div_done`=1.
  - If there is no `mem_stall`, rule 2 is skipped and rules 3–5 apply normally, so the DIV leaves EX.
  - `ex_div` is ignored in DONE; it still refers to the same DIV instruction.
- Register 0 never creates a load-use hazard.
- `stall_cnt` increments by 1 on every cycle with `en_f`=0. It wraps modulo 2^`CNT_W`.

## Timing
- Enables and clears are combinational from the inputs and FSM state, with the same-cycle effect on the next edge.
- `div_busy`/`div_done` are decoded from registered state.
- Divide latency: the DIV occupies EX for `DIV_CYCLES`+2 cycles (detect cycle, BUSY×`DIV_CYCLES`, DONE), plus any `mem_stall` cycles.
- `mem_stall` during BUSY does not pause the counter; the divider keeps running.
- `mem_stall` during IDLE with `ex_div`=1 delays BUSY entry.
- Reset, while `rst`=0 and on release:
  - FSM state is IDLE and the counter is 0.
  - `stall_cnt`=0, `div_busy`=0, `div_done`=0.
  - With idle inputs, all `en_*`=1 and all `clr_*`=0.
- Reset asserted mid-divide aborts it immediately; the FSM returns to IDLE with no DONE pulse.

## Configuration
- `STALL_CNT_EN` defined: the `stall_cnt` register and its increment logic are built as described.
- `STALL_CNT_EN` undefined: the `stall_cnt` port remains but is tied to 0, and no counter flops are inferred.

## Test plan
- Load-use: `ex_memread`=1, `ex_rt`=5, `id_rs`=5 → `en_f`=`en_d`=0, `en_e`=1, `clr_e`=1 for one cycle. The same stimulus with `ex_rt`=0 → no stall.
- Branch: `ex_branch_taken`=1 plus a simultaneous load-use match → all `en_*`=1, `clr_d`=`clr_e`=1, no freeze.
- Divide, `DIV_CYCLES`=4: `ex_div` held high → `en_e`=0 for 5 cycles, `div_busy`=1 for 4 cycles, `div_done`=1 on the 6th cycle with `en_e`=1. The FSM is back in IDLE on the next cycle.
- `mem_stall` during DONE → all enables 0, `div_done` stays 1 until `mem_stall` drops, then a single advance.
- Reset (`rst`=0) asserted in BUSY cycle 2 → `div_busy`=0 asynchronously. After release with idle inputs, all `en_*`=1 and `stall_cnt`=0.
- Counter, with `STALL_CNT_EN`: 3 load-use stalls plus one divide at `DIV_CYCLES`=4 → `stall_cnt`=8. Without `STALL_CNT_EN` → `stall_cnt`=0.
